add_arbiter: RTL and testbench

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arb_pkg.sv | 16 +
 rtl/add_arbiter_adder.sv | 17 +
 rtl/add_arbiter.sv | 132 +++++++++++++
 tb/tb_add_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/add_arb_pkg.sv
// Shared types and constants for the round-robin arbitrated adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_arb_pkg;

  // Default operand and sum width of the shared adder.
  localparam int ADD_WIDTH = 32;

  // Transaction phases of the arbiter.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // arbitrating, may accept one request
    EXEC = 2'd1,  // operands captured, adder evaluating
    RESP = 2'd2   // result presented, waiting for consumer
  } state_t;

endpackage

// File: rtl/add_arbiter_adder.sv
// Combinational WIDTH-bit adder, carry-out dropped (result wraps mod 2^WIDTH).
// Latency: 0 cycles, purely combinational.
// Backpressure: none; output follows inputs.
// Ports: a, b = operands; sum = a + b truncated to WIDTH bits.
module add_arbiter_adder
  import add_arb_pkg::*;
#(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one adder among NUM_REQ requesters.
// Latency: request handshake in cycle T -> rsp_valid high in cycle T+2.
// Backpressure: one transaction in flight; req_ready is zero outside IDLE and the
//   result is held until rsp_ready, so throughput is at most one result per 3 cycles.
// Ports: clk, rst (sync, active-high); req_valid/req_a/req_b/req_ready per requester;
//   rsp_valid/rsp_ready/rsp_sum/rsp_id for the single result channel.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int WIDTH   = ADD_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_a,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [WIDTH-1:0]                rsp_sum,
  output logic [$clog2(NUM_REQ)-1:0]      rsp_id
);

  localparam int ID_W = $clog2(NUM_REQ);
  // Last grant resets to the highest index so requester 0 wins first.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant;
  logic [WIDTH-1:0]  op_a, op_b;
  logic [ID_W-1:0]   op_id;
  logic [WIDTH-1:0]  sum;
  logic [ID_W:0]     pick;
  logic [ID_W-1:0]   grant_id;
  logic              grant_fire;

  // Round-robin pick: {found, index}. The lowest valid index above 'last'
  // wins; if none exists the search wraps to the lowest valid index overall.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    last);
    logic            any_lo, any_hi;
    logic [ID_W-1:0] lo, hi;
    any_lo = 1'b0;
    any_hi = 1'b0;
    lo     = '0;
    hi     = '0;
    // Descending scan so the last hit kept is the lowest index.
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (vld[j]) begin
        any_lo = 1'b1;
        lo     = ID_W'(j);
      end
      if (vld[j] && (j > int'(last))) begin
        any_hi = 1'b1;
        hi     = ID_W'(j);
      end
    end
    if (any_hi) return {1'b1, hi};
    return {any_lo, lo};
  endfunction

  assign pick     = rr_pick(req_valid, last_grant);
  assign grant_id = pick[ID_W-1:0];

  add_arbiter_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state and request-side outputs. The winner is valid by
  // construction, so asserting its ready is itself the handshake.
  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (!rst && pick[ID_W]) begin
          req_ready[grant_id] = 1'b1;
          grant_fire          = 1'b1;
          state_nxt           = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, grant history and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= LAST_RST;
      op_a       <= '0;
      op_b       <= '0;
      op_id      <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_id     <= '0;
    end else begin
      if (grant_fire) begin
        op_a       <= req_a[grant_id];
        op_b       <= req_b[grant_id];
        op_id      <= grant_id;
        last_grant <= grant_id;
      end
      if (state == EXEC) begin
        rsp_sum   <= sum;
        rsp_id    <= op_id;
        rsp_valid <= 1'b1;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed table, corner sequences, random vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_add_arbiter;

  localparam int N = 3;
  localparam int W = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][W-1:0] req_a = '0;
  logic [N-1:0][W-1:0] req_b = '0;
  logic [N-1:0]        req_ready;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [W-1:0]        rsp_sum;
  logic [1:0]          rsp_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  add_arbiter #(
    .NUM_REQ (N),
    .WIDTH   (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_id    (rsp_id)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0] vld;
    logic [W-1:0] a [N];
    logic [W-1:0] b [N];
    int           exp_id;
    logic [W-1:0] exp_sum;
  } vec_t;

  function automatic vec_t mk(input logic [N-1:0] vld,
                              input logic [W-1:0] a0, input logic [W-1:0] a1, input logic [W-1:0] a2,
                              input logic [W-1:0] b0, input logic [W-1:0] b1, input logic [W-1:0] b2,
                              input int id, input logic [W-1:0] s);
    vec_t v;
    v.vld = vld;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    v.exp_id = id;
    v.exp_sum = s;
    return v;
  endfunction

  // One transaction with rsp_ready held high: grant, EXEC, result.
  task automatic do_txn(input vec_t v, input string nm);
    logic [N-1:0] oh;
    @(negedge clk);
    req_valid = v.vld;
    for (int i = 0; i < N; i++) begin
      req_a[i] = v.a[i];
      req_b[i] = v.b[i];
    end
    rsp_ready = 1'b1;
    oh = '0;
    oh[v.exp_id] = 1'b1;
    #1 chk({nm, " grant"}, 64'(req_ready), 64'(oh));
    @(negedge clk);
    #1 chk({nm, " exec_ready"}, 64'(req_ready), 64'd0);
    chk({nm, " exec_valid"}, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1 chk({nm, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, " rsp_sum"}, 64'(rsp_sum), 64'(v.exp_sum));
    chk({nm, " rsp_id"}, 64'(rsp_id), 64'(v.exp_id));
    chk({nm, " resp_ready"}, 64'(req_ready), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t tbl [9];

  // Random-phase model state.
  int           m_last;
  bit           outst;
  int           gcyc;
  int           m_id;
  logic [W-1:0] m_sum;
  int           w;
  int           idx;
  logic [N-1:0] exp_rdy;
  bit           exp_v;
  logic [63:0]  full;

  initial begin
    // Reset state with all requesters asking.
    rst = 1'b1;
    req_valid = '1;
    repeat (3) @(negedge clk);
    #1 chk("rst req_ready", 64'(req_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_sum", 64'(rsp_sum), 64'd0);
    chk("rst rsp_id", 64'(rsp_id), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = '0;

    // First request after reset: 1 + 2 from requester 0.
    do_txn(mk(3'b001, 1, 0, 0, 2, 0, 0, 0, 3), "first");

    do_reset();
    tbl[0] = mk(3'b111, 10, 20, 30, 1, 2, 3, 0, 11);
    tbl[1] = mk(3'b111, 10, 20, 30, 1, 2, 3, 1, 22);
    tbl[2] = mk(3'b111, 10, 20, 30, 1, 2, 3, 2, 33);
    tbl[3] = mk(3'b111, 10, 20, 30, 1, 2, 3, 0, 11);
    tbl[4] = mk(3'b100, 9, 9, 32'hFFFF_FFFF, 9, 9, 32'h0000_0002, 2, 32'h0000_0001);
    tbl[5] = mk(3'b011, 5, 100, 0, 7, 200, 0, 0, 12);
    tbl[6] = mk(3'b011, 5, 100, 0, 7, 200, 0, 1, 300);
    tbl[7] = mk(3'b101, 32'h8000_0000, 0, 3, 32'h8000_0000, 0, 4, 2, 7);
    tbl[8] = mk(3'b101, 32'h8000_0000, 0, 3, 32'h8000_0000, 0, 4, 0, 0);
    for (int t = 0; t < 9; t++) begin
      do_txn(tbl[t], $sformatf("tbl%0d", t));
    end
    @(negedge clk);
    req_valid = '0;
    #1 chk("tbl idle rsp_valid", 64'(rsp_valid), 64'd0);

    // Stalled response: result must hold while rsp_ready is low.
    @(negedge clk);
    req_valid = 3'b010;
    req_a[1] = 7;
    req_b[1] = 8;
    rsp_ready = 1'b0;
    #1 chk("stall grant", 64'(req_ready), 64'b010);
    @(negedge clk);
    req_valid = 3'b111;
    #1 chk("stall exec_ready", 64'(req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1 chk($sformatf("stall%0d valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("stall%0d sum", k), 64'(rsp_sum), 64'd15);
      chk($sformatf("stall%0d id", k), 64'(rsp_id), 64'd1);
      chk($sformatf("stall%0d ready", k), 64'(req_ready), 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1 chk("stall release valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    #1 chk("stall idle valid", 64'(rsp_valid), 64'd0);
    chk("stall next grant", 64'(req_ready), 64'b100);
    req_valid = '0;

    // Reset while in EXEC discards the transaction and restarts priority at 0.
    @(negedge clk);
    req_valid = 3'b001;
    req_a[0] = 5;
    req_b[0] = 6;
    #1 chk("exrst grant", 64'(req_ready), 64'b001);
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    @(negedge clk);
    req_valid = 3'b011;
    #1 chk("exrst valid", 64'(rsp_valid), 64'd0);
    chk("exrst sum", 64'(rsp_sum), 64'd0);
    chk("exrst id", 64'(rsp_id), 64'd0);
    chk("exrst ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("exrst regrant", 64'(req_ready), 64'b001);
    @(negedge clk);
    req_valid = '0;
    #1 chk("exrst exec", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    #1 chk("exrst rsp_valid", 64'(rsp_valid), 64'd1);
    chk("exrst rsp_sum", 64'(rsp_sum), 64'd11);
    chk("exrst rsp_id", 64'(rsp_id), 64'd0);

    // Randomized traffic against a transaction-level model.
    do_reset();
    m_last = N - 1;
    outst  = 1'b0;
    gcyc   = 0;
    m_id   = 0;
    m_sum  = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      req_valid = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      w = -1;
      if (!outst) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (w < 0 && req_valid[idx]) w = idx;
        end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      exp_v = outst && (c >= gcyc + 2);
      #1 chk($sformatf("rnd%0d ready", c), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("rnd%0d valid", c), 64'(rsp_valid), 64'(exp_v));
      if (exp_v) begin
        chk($sformatf("rnd%0d sum", c), 64'(rsp_sum), 64'(m_sum));
        chk($sformatf("rnd%0d id", c), 64'(rsp_id), 64'(m_id));
      end
      if (w >= 0) begin
        outst  = 1'b1;
        gcyc   = c;
        m_id   = w;
        m_last = w;
        full   = 64'(req_a[w]) + 64'(req_b[w]);
        m_sum  = full[W-1:0];
      end else if (exp_v && rsp_ready) begin
        outst = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
